led_key_ctrl: RTL and testbench
===============================

LED_KEY_CTRL -- requirements
Module: led_key_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 4, meaning the number of LED outputs (legal range 2..32).
REQ-002 The block SHALL have parameter DEBOUNCE_CYC, default 8192, meaning the stable-high cycles required to accept a key press (legal range 1..2^20).
REQ-003 The block SHALL have parameter TICK_CYC, default 2^25, meaning the clock cycles per pattern step at speed 0 (legal range 2..2^28).
REQ-004 The block SHALL have parameter LED_ACTIVE_LOW, default 0, meaning that 1 inverts all led outputs.
REQ-005 The block SHALL have port clk_50m, input, width 1, meaning the single clock.
REQ-006 The block SHALL have port rst, input, width 1, meaning the synchronous active-high reset.
REQ-007 The block SHALL have port key, input, width 2, meaning asynchronous raw buttons: key[0] selects the next mode and key[1] the previous mode.
REQ-008 The block SHALL have port speed, input, width 2, meaning the step period is TICK_CYC >> speed cycles, floored at 2.
REQ-009 The block SHALL have port enable, input, width 1, meaning that low freezes the pattern.
REQ-010 The block SHALL have port led, output, width NUM_LEDS, meaning the registered pattern output.
REQ-011 The block SHALL have port mode, output, width 2, meaning the current mode.
REQ-012 The block SHALL have port heartbeat, output, width 1, meaning it toggles on every step tick.
REQ-013 The block SHALL have port key_evt, output, width 2, meaning a one-cycle pulse for each accepted press.

Function
REQ-014 Each key bit SHALL pass through a 2-flop synchroniser before any other logic uses it.
REQ-015 Each key SHALL have a counter that increments while its synchronised key is high, saturates at DEBOUNCE_CYC, and clears in the cycle after the synchronised key goes low.
REQ-016 The debounced key SHALL be high exactly when its counter equals DEBOUNCE_CYC.
REQ-017 key_evt[i] SHALL pulse for one cycle on each rising edge of debounced key i, with no further pulse until key i is released and pressed again.
REQ-018 With key[i] held high, key_evt[i] SHALL assert exactly DEBOUNCE_CYC+3 rising edges after the first edge that samples key[i] high.
REQ-019 A low glitch of any length on key[i] SHALL restart its count.
REQ-020 A key_evt[0] pulse SHALL set mode to mode+1 mod 4, and a key_evt[1] pulse SHALL set mode to mode-1 mod 4; the update SHALL be registered and visible in the cycle after the pulse.
REQ-021 If key_evt[0] and key_evt[1] pulse in the same cycle, mode SHALL be unchanged.
REQ-022 The prescaler SHALL count 0..P-1, where P = max(TICK_CYC>>speed, 2), and emit a one-cycle tick on wrap.
REQ-023 A change of speed SHALL take effect at the next wrap, and SHALL never drive a count past P-1: if the count is already at or above the new P-1, the prescaler SHALL wrap immediately.
REQ-024 While enable is low, the prescaler, position, phase and led SHALL hold; mode changes SHALL still be accepted.
REQ-025 On tick, the state SHALL update per mode as follows:
- mode 0 BLINK: phase toggles; led = all phase.
- mode 1 SHIFT_L: pos advances 0,1,..,N-1,0; led is one-hot at pos.
- mode 2 SHIFT_R: pos steps N-1,..,0,N-1; led is one-hot at pos.
- mode 3 BOUNCE: pos runs 0..N-1..0 with a direction flag; end points are not repeated (N=2 simply alternates); led is one-hot at pos.
REQ-026 On any mode change, the prescaler SHALL clear to 0, phase SHALL clear to 0, direction SHALL be set to up, and pos SHALL load 0 (N-1 for mode 2); led SHALL show the initial pattern of the new mode in the cycle after the mode update.
REQ-027 heartbeat SHALL toggle on every tick, independent of mode.
REQ-028 The led output SHALL be XORed with LED_ACTIVE_LOW replicated across all bits, applied at the output register.

Reset
REQ-029 With rst high at a clock edge, the following SHALL clear: synchronisers, debounce counters, key_evt=0, mode=0, prescaler=0, pos=0, phase=0, direction=up, heartbeat=0, led = all-off (all 1 if LED_ACTIVE_LOW).
REQ-030 rst SHALL override a key press, a tick or a mode change in the same cycle.
REQ-031 A press in progress at reset SHALL require a full DEBOUNCE_CYC count after release of rst.

Verification
REQ-032 All scenarios SHALL use NUM_LEDS=4, DEBOUNCE_CYC=8, TICK_CYC=4, speed=0, enable=1.
REQ-033 Debounce: key[0] high from edge 0 SHALL give key_evt[0] at edge 11 only, and mode SHALL go 0->1.
REQ-034 Glitch: key[0] high 7 cycles, low 1, then high SHALL give key_evt pulse 11 edges after the re-rise, and no earlier pulse.
REQ-035 Wrap: four key[1] presses from mode 0 SHALL give mode 3,2,1,0; simultaneous presses SHALL leave mode unchanged.
REQ-036 Pattern: mode 3, ticks every 4 cycles, SHALL give led 0001,0010,0100,1000,0100,0010,0001, and heartbeat SHALL toggle on each tick.
REQ-037 Freeze/speed: enable=0 for 20 cycles SHALL hold led; speed=1 SHALL give ticks every 2 cycles; speed=3 SHALL give ticks every 2 cycles (floored at 2).
REQ-038 Reset mid-pattern (mode 2, pos 1) SHALL return led=0000, mode=0, and first tick SHALL come 4 cycles after rst falls.

Source files
------------

// File: rtl/led_key_ctrl.sv
// LED pattern generator with debounced mode keys.
// Two keys step the mode; a prescaler paces the pattern.
module led_key_ctrl #(
  parameter int NUM_LEDS       = 4,
  parameter int DEBOUNCE_CYC   = 8192,
  parameter int TICK_CYC       = 33554432,
  parameter int LED_ACTIVE_LOW = 0
) (
  input  logic                clk_50m,
  input  logic                rst,
  input  logic [1:0]          key,
  input  logic [1:0]          speed,
  input  logic                enable,
  output logic [NUM_LEDS-1:0] led,
  output logic [1:0]          mode,
  output logic                heartbeat,
  output logic [1:0]          key_evt
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int CW = $clog2(TICK_CYC + 1);
  localparam int PW = $clog2(NUM_LEDS);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYC);
  localparam logic [CW-1:0] TICK_P = CW'(TICK_CYC);
  localparam logic [PW-1:0] POS_TOP = PW'(NUM_LEDS - 1);
  localparam logic [NUM_LEDS-1:0] LED_MASK =
    (LED_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    M_BLINK   = 2'd0,
    M_SHIFT_L = 2'd1,
    M_SHIFT_R = 2'd2,
    M_BOUNCE  = 2'd3
  } mode_t;

  logic [1:0]          r_sync1;
  logic [1:0]          r_sync2;
  logic [DW-1:0]       r_dcnt [2];
  logic [1:0]          w_deb;
  logic [1:0]          r_deb_q;
  logic [1:0]          r_deb_qq;
  logic [1:0]          r_evt;
  mode_t               r_mode;
  mode_t               w_mode_nxt;
  logic                w_mode_chg;
  logic [CW-1:0]       w_shift;
  logic [CW-1:0]       w_per;
  logic [CW-1:0]       r_pre;
  logic                w_tick;
  logic                r_hb;
  logic [PW-1:0]       r_pos;
  logic                r_phase;
  logic                r_up;
  logic [NUM_LEDS-1:0] w_pat;
  logic [NUM_LEDS-1:0] r_led;

  // two-flop synchroniser on the raw buttons
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= key;
      r_sync2 <= r_sync1;
    end
  end

  // saturating stable-high counters, cleared by any low sample
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_dcnt[0] <= '0;
      r_dcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!r_sync2[i])
          r_dcnt[i] <= '0;
        else if (r_dcnt[i] != DEB_MAX)
          r_dcnt[i] <= r_dcnt[i] + DW'(1);
      end
    end
  end

  assign w_deb = {r_dcnt[1] == DEB_MAX, r_dcnt[0] == DEB_MAX};

  // rising-edge detect of the debounced keys into one-cycle events
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_deb_q  <= '0;
      r_deb_qq <= '0;
      r_evt    <= '0;
    end else begin
      r_deb_q  <= w_deb;
      r_deb_qq <= r_deb_q;
      r_evt    <= r_deb_q & ~r_deb_qq;
    end
  end

  // mode state register
  always_ff @(posedge clk_50m) begin
    if (rst) r_mode <= M_BLINK;
    else     r_mode <= w_mode_nxt;
  end

  // next mode: up on key 0, down on key 1, both cancel
  always_comb begin
    w_mode_nxt = r_mode;
    w_mode_chg = 1'b0;
    unique case (1'b1)
      (r_evt == 2'b01): begin
        w_mode_nxt = mode_t'(r_mode + 2'd1);
        w_mode_chg = 1'b1;
      end
      (r_evt == 2'b10): begin
        w_mode_nxt = mode_t'(r_mode - 2'd1);
        w_mode_chg = 1'b1;
      end
      default: ;
    endcase
  end

  // step period, floored at two cycles; wrap when at or past the end
  always_comb begin
    w_shift = TICK_P >> speed;
    w_per   = (w_shift < CW'(2)) ? CW'(2) : w_shift;
    w_tick  = enable && (r_pre >= w_per - CW'(1));
  end

  // prescaler, restarted by a mode change
  always_ff @(posedge clk_50m) begin
    if (rst)
      r_pre <= '0;
    else if (w_mode_chg || w_tick)
      r_pre <= '0;
    else if (enable)
      r_pre <= r_pre + CW'(1);
  end

  // heartbeat flips on every step
  always_ff @(posedge clk_50m) begin
    if (rst)         r_hb <= 1'b0;
    else if (w_tick) r_hb <= ~r_hb;
  end

  // pattern position, phase and bounce direction
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_pos   <= '0;
      r_phase <= 1'b0;
      r_up    <= 1'b1;
    end else if (w_mode_chg) begin
      r_pos   <= (w_mode_nxt == M_SHIFT_R) ? POS_TOP : '0;
      r_phase <= 1'b0;
      r_up    <= 1'b1;
    end else if (w_tick) begin
      unique case (r_mode)
        M_BLINK:   r_phase <= ~r_phase;
        M_SHIFT_L: r_pos <= (r_pos == POS_TOP) ? '0 : r_pos + PW'(1);
        M_SHIFT_R: r_pos <= (r_pos == '0) ? POS_TOP : r_pos - PW'(1);
        M_BOUNCE: begin
          if (r_up) begin
            if (r_pos == POS_TOP) begin
              r_up  <= 1'b0;
              r_pos <= r_pos - PW'(1);
            end else begin
              r_pos <= r_pos + PW'(1);
            end
          end else begin
            if (r_pos == '0) begin
              r_up  <= 1'b1;
              r_pos <= r_pos + PW'(1);
            end else begin
              r_pos <= r_pos - PW'(1);
            end
          end
        end
      endcase
    end
  end

  // led image of the current state
  always_comb begin
    w_pat = '0;
    if (r_mode == M_BLINK) w_pat = {NUM_LEDS{r_phase}};
    else                   w_pat = NUM_LEDS'(1) << r_pos;
  end

  // registered led output with polarity applied
  always_ff @(posedge clk_50m) begin
    if (rst) r_led <= LED_MASK;
    else     r_led <= w_pat ^ LED_MASK;
  end

  assign led       = r_led;
  assign mode      = r_mode;
  assign heartbeat = r_hb;
  assign key_evt   = r_evt;

endmodule

// File: tb/tb_led_key_ctrl.sv
// Scenario bench for led_key_ctrl.
// Expectations are queued as stimulus is driven.
module tb_led_key_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] key = 2'b00;
  logic [1:0] speed = 2'b00;
  logic       enable = 1'b1;
  logic [3:0] led;
  logic [1:0] mode;
  logic       heartbeat;
  logic [1:0] key_evt;

  int n_cmp = 0;
  int n_bad = 0;
  int m_model = 0;

  logic [1:0] q_evt[$];
  logic [1:0] q_mode[$];
  logic [3:0] q_led[$];
  bit         q_tog[$];
  logic       prev_hb;

  led_key_ctrl #(
    .NUM_LEDS(4),
    .DEBOUNCE_CYC(8),
    .TICK_CYC(4),
    .LED_ACTIVE_LOW(0)
  ) dut (
    .clk_50m(clk),
    .rst(rst),
    .key(key),
    .speed(speed),
    .enable(enable),
    .led(led),
    .mode(mode),
    .heartbeat(heartbeat),
    .key_evt(key_evt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] el;
    logic [1:0] em, ee;
    q_led.push_back(4'b0000);
    q_mode.push_back(2'd0);
    q_evt.push_back(2'b00);
    rst = 1'b1; key = 2'b00; speed = 2'b00; enable = 1'b1;
    repeat (3) cyc();
    el = q_led.pop_front();
    em = q_mode.pop_front();
    ee = q_evt.pop_front();
    n_cmp++;
    if (led !== el) begin
      n_bad++;
      $display("FAIL reset_led: got %b, required %b", led, el);
    end
    n_cmp++;
    if (mode !== em) begin
      n_bad++;
      $display("FAIL reset_mode: got %0d, required %0d", mode, em);
    end
    n_cmp++;
    if (key_evt !== ee) begin
      n_bad++;
      $display("FAIL reset_evt: got %b, required %b", key_evt, ee);
    end
    n_cmp++;
    if (heartbeat !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hb: got %b, required 0", heartbeat);
    end
    rst = 1'b0;
  endtask

  task automatic test_debounce();
    logic [1:0] ee, em;
    for (int e = 0; e < 20; e++) begin
      q_evt.push_back((e == 11) ? 2'b01 : 2'b00);
      q_mode.push_back((e >= 12) ? 2'd1 : 2'd0);
    end
    key = 2'b01;
    for (int e = 0; e < 20; e++) begin
      cyc();
      ee = q_evt.pop_front();
      em = q_mode.pop_front();
      n_cmp++;
      if (key_evt !== ee) begin
        n_bad++;
        $display("FAIL debounce_evt e%0d: got %b, required %b", e, key_evt, ee);
      end
      n_cmp++;
      if (mode !== em) begin
        n_bad++;
        $display("FAIL debounce_mode e%0d: got %0d, required %0d", e, mode, em);
      end
    end
    key = 2'b00;
    repeat (6) cyc();
  endtask

  task automatic test_glitch();
    logic [1:0] ee, em;
    for (int e = 0; e < 23; e++) begin
      q_evt.push_back((e == 19) ? 2'b01 : 2'b00);
      q_mode.push_back((e >= 20) ? 2'd2 : 2'd1);
    end
    key = 2'b01;
    for (int e = 0; e < 23; e++) begin
      cyc();
      ee = q_evt.pop_front();
      em = q_mode.pop_front();
      n_cmp++;
      if (key_evt !== ee) begin
        n_bad++;
        $display("FAIL glitch_evt e%0d: got %b, required %b", e, key_evt, ee);
      end
      n_cmp++;
      if (mode !== em) begin
        n_bad++;
        $display("FAIL glitch_mode e%0d: got %0d, required %0d", e, mode, em);
      end
      if (e == 6) key = 2'b00;
      if (e == 7) key = 2'b01;
    end
    key = 2'b00;
    repeat (6) cyc();
  endtask

  task automatic press(input logic [1:0] k);
    int nxt;
    logic [1:0] ee, em;
    nxt = m_model;
    if (k == 2'b01) nxt = (m_model + 1) % 4;
    if (k == 2'b10) nxt = (m_model + 3) % 4;
    q_evt.push_back(k);
    q_mode.push_back(2'(nxt));
    key = k;
    for (int e = 0; e < 13; e++) begin
      cyc();
      if (e == 11) begin
        ee = q_evt.pop_front();
        n_cmp++;
        if (key_evt !== ee) begin
          n_bad++;
          $display("FAIL wrap_evt: got %b, required %b", key_evt, ee);
        end
      end
      if (e == 12) begin
        em = q_mode.pop_front();
        n_cmp++;
        if (mode !== em) begin
          n_bad++;
          $display("FAIL wrap_mode: got %0d, required %0d", mode, em);
        end
      end
    end
    key = 2'b00;
    repeat (6) cyc();
    m_model = nxt;
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    m_model = 0;
    repeat (4) press(2'b10);
    press(2'b11);
  endtask

  task automatic test_pattern();
    logic [3:0] seq [8];
    logic [3:0] el;
    logic [1:0] em;
    bit et;
    seq[0] = 4'b0001; seq[1] = 4'b0010;
    seq[2] = 4'b0100; seq[3] = 4'b1000;
    seq[4] = 4'b0100; seq[5] = 4'b0010;
    seq[6] = 4'b0001; seq[7] = 4'b0010;
    q_mode.push_back(2'd3);
    for (int e = 13; e < 42; e++) q_led.push_back(seq[(e - 13) / 4]);
    for (int e = 14; e < 42; e++) q_tog.push_back((e >= 16) && ((e - 16) % 4 == 0));
    key = 2'b10;
    for (int e = 0; e < 42; e++) begin
      cyc();
      if (e == 12) begin
        em = q_mode.pop_front();
        n_cmp++;
        if (mode !== em) begin
          n_bad++;
          $display("FAIL pattern_mode: got %0d, required %0d", mode, em);
        end
      end
      if (e >= 13) begin
        el = q_led.pop_front();
        n_cmp++;
        if (led !== el) begin
          n_bad++;
          $display("FAIL pattern_led e%0d: got %b, required %b", e, led, el);
        end
      end
      if (e >= 14) begin
        et = q_tog.pop_front();
        n_cmp++;
        if ((heartbeat ^ prev_hb) !== et) begin
          n_bad++;
          $display("FAIL pattern_hb e%0d: got toggle %b, required %b", e, heartbeat ^ prev_hb, et);
        end
      end
      if (e == 13) key = 2'b00;
      prev_hb = heartbeat;
    end
  endtask

  task automatic test_freeze();
    logic [3:0] el;
    bit et;
    for (int i = 0; i < 20; i++) begin
      q_led.push_back(4'b0010);
      q_tog.push_back(1'b0);
    end
    q_led.push_back(4'b0010); q_tog.push_back(1'b0);
    q_led.push_back(4'b0010); q_tog.push_back(1'b0);
    q_led.push_back(4'b0010); q_tog.push_back(1'b1);
    q_led.push_back(4'b0100); q_tog.push_back(1'b0);
    enable = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 20) enable = 1'b1;
      cyc();
      el = q_led.pop_front();
      et = q_tog.pop_front();
      n_cmp++;
      if (led !== el) begin
        n_bad++;
        $display("FAIL freeze_led c%0d: got %b, required %b", i, led, el);
      end
      n_cmp++;
      if ((heartbeat ^ prev_hb) !== et) begin
        n_bad++;
        $display("FAIL freeze_hb c%0d: got toggle %b, required %b", i, heartbeat ^ prev_hb, et);
      end
      prev_hb = heartbeat;
    end
  endtask

  task automatic test_speed();
    bit et;
    for (int i = 0; i < 12; i++) q_tog.push_back(i % 2 == 0);
    speed = 2'd1;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) speed = 2'd3;
      cyc();
      et = q_tog.pop_front();
      n_cmp++;
      if ((heartbeat ^ prev_hb) !== et) begin
        n_bad++;
        $display("FAIL speed%0d_hb c%0d: got toggle %b, required %b", speed, i, heartbeat ^ prev_hb, et);
      end
      prev_hb = heartbeat;
    end
    speed = 2'd0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] el;
    logic [1:0] em;
    bit eh;
    q_mode.push_back(2'd2);
    q_led.push_back(4'b1000);
    q_led.push_back(4'b0010);
    q_mode.push_back(2'd2);
    for (int e = 22; e < 24; e++) begin
      q_led.push_back(4'b0000);
      q_mode.push_back(2'd0);
    end
    for (int e = 22; e < 28; e++) q_tog.push_back(e == 27);
    q_led.push_back(4'b0000);
    key = 2'b10;
    for (int e = 0; e < 28; e++) begin
      cyc();
      if (e == 12 || e == 21 || e == 22 || e == 23) begin
        em = q_mode.pop_front();
        n_cmp++;
        if (mode !== em) begin
          n_bad++;
          $display("FAIL rstmid_mode e%0d: got %0d, required %0d", e, mode, em);
        end
      end
      if (e == 13 || e == 21 || e == 22 || e == 23 || e == 27) begin
        el = q_led.pop_front();
        n_cmp++;
        if (led !== el) begin
          n_bad++;
          $display("FAIL rstmid_led e%0d: got %b, required %b", e, led, el);
        end
      end
      if (e >= 22) begin
        eh = q_tog.pop_front();
        n_cmp++;
        if (heartbeat !== eh) begin
          n_bad++;
          $display("FAIL rstmid_hb e%0d: got %b, required %b", e, heartbeat, eh);
        end
      end
      if (e == 13) key = 2'b00;
      if (e == 21) rst = 1'b1;
      if (e == 23) rst = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_wrap();
    test_pattern();
    test_freeze();
    test_speed();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
